seg_pattern_decoder: RTL and testbench
======================================

// Module: seg_pattern_decoder
// PURPOSE
//  Receive side of the 7-segment interface: samples a multiplexed, active-low segment bus
//  (seg_in[6:0] = g..a, 0 = lit) plus a one-hot digit strobe, and converts each pattern back to a 4-bit code.
//  Debounces each pattern, detects per-digit changes and reports them on a valid/ready stream.
//  Sits between a display bus tap and the self-check / scoreboard logic.
// PARAMETERS
//  DIGITS        4   number of multiplexed digits (1..8)
//  STABLE_CYCLES 8   consecutive identical samples required before a pattern is accepted (>=2)
// PORTS
//  clk        in   1                 single system clock, all logic rising-edge
//  reset      in   1                 synchronous, active-high reset
//  seg_in     in   7                 active-low segment pattern, bit0 = a .. bit6 = g
//  digit_sel  in   DIGITS            one-hot digit strobe; zero or multi-hot = bus blanked
//  out_valid  out  1                 change event pending
//  out_ready  in   1                 consumer accepts event when out_valid & out_ready
//  out_code   out  4                 decoded code of event
//  out_digit  out  $clog2(DIGITS)    digit index of event (min width 1)
//  out_inval  out  1                 pattern not in code table
//  overrun    out  1                 sticky: event lost while previous one unaccepted
// BEHAVIOUR
//  - Code table (pattern -> code): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4,
//    0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0101111->A(R), 0001000->B(A),
//    1000110->C(C), 0001001->D(H), 0000110->E(E), 1111111->F(blank). Any other pattern: code 0, inval 1.
//  - Reset: out_valid=0, out_code=0, out_digit=0, out_inval=0, overrun=0, stability counter=0,
//    per-digit shadow table = {code F, inval 0, known 0} for every digit.
//  - Stability filter: registered sample {seg_in,digit_sel}; counter increments while the current sample
//    equals the previous one, saturating at STABLE_CYCLES; any difference or blanked strobe resets it to 0.
//    Accept pulse fires exactly once, on the cycle the counter reaches STABLE_CYCLES-1 -> STABLE_CYCLES.
//  - Change detect: on accept, decode via LUT; event generated iff shadow[digit] not known or
//    {code,inval} differs from shadow; shadow[digit] updated on every accept regardless.
//  - Latency: first sample of a new steady pattern at edge N -> out_valid high after edge N+STABLE_CYCLES.
//  - FSM (2 states):
//      S_IDLE: out_valid=0; event -> load out_* registers, go S_HOLD.
//      S_HOLD: out_valid=1, out_* held stable; out_valid&out_ready -> S_IDLE, unless a new event
//              occurs in the same cycle, in which case load it and stay S_HOLD (no bubble, no overrun).
//              New event without out_ready -> event dropped, overrun<=1, out_* unchanged.
//  - overrun clears only on reset.
//  - Reset asserted mid-pattern or mid-handshake: all state returns to reset values next edge; pending
//    event discarded; no partial output.
//  - Blanked strobe never produces an event and never alters the shadow table.
// STRUCTURE
//  - Shared package: 7-bit pattern constants for the 16 codes, code constants (CODE_R..CODE_OFF),
//    FSM state encoding.
//  - Sub-module seg_pattern_lut: purely combinational seg[6:0] -> {code[3:0], inval}.
//  - Top holds sampler, stability counter, shadow table (DIGITS x 6 bits), FSM and output registers.
// TESTING
//  1 Reset: assert reset 3 cycles with random inputs -> all outputs 0, no out_valid for 20 cycles after.
//  2 digit_sel=0001, seg_in=0100100 held 8 cycles, out_ready=1 -> out_valid 1 cycle, code 2, digit 0, inval 0;
//    holding 50 more cycles -> no further event.
//  3 Glitch: seg_in=0011001 for 7 cycles then 1 cycle 0011000 then 0011001 x8 -> single event code 4
//    after the final 8-cycle run; unknown pattern 0011000 held 8 cycles -> code 0, inval 1.
//  4 Backpressure: out_ready=0; digit 1 -> 0001000 (code B), then digit 2 -> 1000110 -> first event held,
//    overrun=1, second lost; release ready -> exactly one transfer of code B, digit 1.
//  5 Back-to-back: event pending, out_ready=1 in cycle a new event fires -> both transferred in order,
//    overrun stays 0.
//  6 Reset mid-hold: out_valid=1, assert reset -> out_valid=0 next edge; re-send same pattern ->
//    event reported again (shadow cleared).

Source files
------------

// File: rtl/seg_pattern_decoder_pkg.sv
// Shared constants for the 7-segment receive path: segment patterns (g..a, active low),
// decoded codes for the letter glyphs, and the output handshake state encoding.
package seg_pattern_decoder_pkg;

    // Active-low patterns, bit 6 = g .. bit 0 = a
    localparam logic [6:0] Pat0   = 7'b1000000;
    localparam logic [6:0] Pat1   = 7'b1111001;
    localparam logic [6:0] Pat2   = 7'b0100100;
    localparam logic [6:0] Pat3   = 7'b0110000;
    localparam logic [6:0] Pat4   = 7'b0011001;
    localparam logic [6:0] Pat5   = 7'b0010010;
    localparam logic [6:0] Pat6   = 7'b0000010;
    localparam logic [6:0] Pat7   = 7'b1111000;
    localparam logic [6:0] Pat8   = 7'b0000000;
    localparam logic [6:0] Pat9   = 7'b0010000;
    localparam logic [6:0] PatR   = 7'b0101111;
    localparam logic [6:0] PatA   = 7'b0001000;
    localparam logic [6:0] PatC   = 7'b1000110;
    localparam logic [6:0] PatH   = 7'b0001001;
    localparam logic [6:0] PatE   = 7'b0000110;
    localparam logic [6:0] PatOff = 7'b1111111;

    localparam logic [3:0] CodeR   = 4'hA;
    localparam logic [3:0] CodeA   = 4'hB;
    localparam logic [3:0] CodeC   = 4'hC;
    localparam logic [3:0] CodeH   = 4'hD;
    localparam logic [3:0] CodeE   = 4'hE;
    localparam logic [3:0] CodeOff = 4'hF;

    typedef enum logic {
        StIdle,
        StHold
    } out_state_e;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational segment-pattern to code decoder; unknown patterns give code 0 with inval set.
module seg_pattern_lut
    import seg_pattern_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       inval_o
);

    // Table lookup of the 16 legal glyphs
    always_comb begin
        code_o  = 4'h0;
        inval_o = 1'b0;
        case (seg_i)
            Pat0:    code_o = 4'h0;
            Pat1:    code_o = 4'h1;
            Pat2:    code_o = 4'h2;
            Pat3:    code_o = 4'h3;
            Pat4:    code_o = 4'h4;
            Pat5:    code_o = 4'h5;
            Pat6:    code_o = 4'h6;
            Pat7:    code_o = 4'h7;
            Pat8:    code_o = 4'h8;
            Pat9:    code_o = 4'h9;
            PatR:    code_o = CodeR;
            PatA:    code_o = CodeA;
            PatC:    code_o = CodeC;
            PatH:    code_o = CodeH;
            PatE:    code_o = CodeE;
            PatOff:  code_o = CodeOff;
            default: inval_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Receive side of a multiplexed 7-segment bus: debounces each digit's pattern, decodes it,
// reports per-digit changes on a valid/ready stream and flags lost events as overrun.
module seg_pattern_decoder
    import seg_pattern_decoder_pkg::*;
#(
    parameter int unsigned  DIGITS        = 4,
    parameter int unsigned  STABLE_CYCLES = 8,
    localparam int unsigned DigW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [6:0]        seg_in_i,
    input  logic [DIGITS-1:0] digit_sel_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        out_code_o,
    output logic [DigW-1:0]   out_digit_o,
    output logic              out_inval_o,
    output logic              overrun_o
);

    localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntPre = CntW'(STABLE_CYCLES - 1);

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] sel_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              in_blank, same, accept, event_fire;
    logic [DigW-1:0]   dig_idx;
    logic [3:0]        lut_code;
    logic              lut_inval;

    logic [DIGITS-1:0][3:0] sh_code_q;
    logic [DIGITS-1:0]      sh_inval_q;
    logic [DIGITS-1:0]      sh_known_q;

    out_state_e      state_q;
    logic            valid_q, inval_q, overrun_q;
    logic [3:0]      code_q;
    logic [DigW-1:0] digit_q;

    // Stability counter: counts consecutive identical one-hot samples, saturating
    always_comb begin
        in_blank = !$onehot(digit_sel_i);
        same     = (seg_in_i == seg_q) && (digit_sel_i == sel_q);
        if (in_blank || !same) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        // Single-cycle accept on the S-1 -> S transition only
        accept = !in_blank && same && (cnt_q == CntPre);
    end

    // Sample register and counter; the sample clears on reset so the first post-reset
    // pattern always starts a fresh run
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seg_q <= '0;
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            seg_q <= seg_in_i;
            sel_q <= digit_sel_i;
            cnt_q <= cnt_d;
        end
    end

    // One-hot strobe to digit index
    always_comb begin
        dig_idx = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sel_q[i]) begin
                dig_idx = DigW'(i);
            end
        end
    end

    seg_pattern_lut u_lut (
        .seg_i   (seg_q),
        .code_o  (lut_code),
        .inval_o (lut_inval)
    );

    // Event when the digit was never seen or its decoded value changed
    always_comb begin
        event_fire = accept && (!sh_known_q[dig_idx] ||
                                (sh_code_q[dig_idx] != lut_code) ||
                                (sh_inval_q[dig_idx] != lut_inval));
    end

    // Per-digit shadow of the last accepted value, refreshed on every accept
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sh_code_q  <= {DIGITS{CodeOff}};
            sh_inval_q <= '0;
            sh_known_q <= '0;
        end else if (accept) begin
            sh_code_q[dig_idx]  <= lut_code;
            sh_inval_q[dig_idx] <= lut_inval;
            sh_known_q[dig_idx] <= 1'b1;
        end
    end

    // Output handshake FSM with registered outputs; a transfer and a new event in the same
    // cycle reload without a bubble
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            code_q    <= 4'h0;
            digit_q   <= '0;
            inval_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (event_fire) begin
                        code_q  <= lut_code;
                        digit_q <= dig_idx;
                        inval_q <= lut_inval;
                        valid_q <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        if (event_fire) begin
                            code_q  <= lut_code;
                            digit_q <= dig_idx;
                            inval_q <= lut_inval;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else if (event_fire) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_valid_o = valid_q;
    assign out_code_o  = code_q;
    assign out_digit_o = digit_q;
    assign out_inval_o = inval_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed and randomized bench for seg_pattern_decoder with a cycle-level reference model.
module tb_seg_pattern_decoder;

    localparam int S = 8;
    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       ready;
    logic       out_valid;
    logic [3:0] out_code;
    logic [1:0] out_digit;
    logic       out_inval;
    logic       overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state
    logic [6:0]  pat_tab [16];
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_sh_code [D];
    logic        m_sh_inval [D];
    logic        m_known [D];
    logic        m_valid, m_inval, m_ovr;
    logic [3:0]  m_code;
    logic [1:0]  m_digit;

    seg_pattern_decoder #(
        .DIGITS        (D),
        .STABLE_CYCLES (S)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .seg_in_i    (seg),
        .digit_sel_i (sel),
        .out_valid_o (out_valid),
        .out_ready_i (ready),
        .out_code_o  (out_code),
        .out_digit_o (out_digit),
        .out_inval_o (out_inval),
        .overrun_o   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, evaluated from the inputs that edge will sample
    task automatic model_step();
        logic [10:0] key;
        logic [3:0]  c;
        logic        iv;
        logic        ev;
        int          d;
        if (rst) begin
            m_prev  = '0;
            m_run   = 0;
            m_valid = 0;
            m_code  = 0;
            m_digit = 0;
            m_inval = 0;
            m_ovr   = 0;
            for (int i = 0; i < D; i++) begin
                m_sh_code[i]  = 4'hF;
                m_sh_inval[i] = 0;
                m_known[i]    = 0;
            end
            return;
        end
        key = {seg, sel};
        if ($countones(sel) == 1 && key == m_prev) m_run++;
        else m_run = 0;
        m_prev = key;
        ev = 0;
        c  = 0;
        iv = 1;
        d  = 0;
        if (m_run == S) begin
            for (int i = 0; i < 16; i++) begin
                if (pat_tab[i] == seg) begin
                    c  = 4'(i);
                    iv = 0;
                end
            end
            for (int i = 0; i < D; i++) if (sel[i]) d = i;
            ev = !m_known[d] || m_sh_code[d] != c || m_sh_inval[d] != iv;
            m_sh_code[d]  = c;
            m_sh_inval[d] = iv;
            m_known[d]    = 1;
        end
        if (m_valid && ready) m_valid = 0;
        if (ev) begin
            if (!m_valid) begin
                m_valid = 1;
                m_code  = c;
                m_digit = 2'(d);
                m_inval = iv;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("model_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("model_code", out_code, m_code);
            chk("model_digit", out_digit, m_digit);
            chk("model_inval", out_inval, m_inval);
        end
        chk("model_overrun", overrun, m_ovr);
    endtask

    // One clock: model, edge, then compare on the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_valid(input string tag, input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < bound);
        chk(tag, out_valid, 1);
    endtask

    int n, cnt;

    initial begin
        pat_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0101111, 7'b0001000,
                    7'b1000110, 7'b0001001, 7'b0000110, 7'b1111111};
        rst   = 1;
        seg   = 7'($urandom);
        sel   = 4'($urandom);
        ready = 1'($urandom);
        @(negedge clk);

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            seg = 7'($urandom);
            sel = 4'($urandom);
            tick();
        end
        chk("rst_valid", out_valid, 0);
        chk("rst_code", out_code, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_inval", out_inval, 0);
        chk("rst_overrun", overrun, 0);
        rst = 0;
        sel = 4'b0000;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            seg = 7'($urandom);
            tick();
            if (out_valid) cnt++;
        end
        chk("rst_quiet", cnt, 0);

        // 2: steady pattern on digit 0
        ready = 1;
        sel   = 4'b0001;
        seg   = 7'b0100100;
        wait_valid("t2_valid", 20, n);
        chk("t2_latency", n, S + 1);
        chk("t2_code", out_code, 2);
        chk("t2_digit", out_digit, 0);
        chk("t2_inval", out_inval, 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("t2_no_repeat", cnt, 0);

        // 3: glitch restarts the filter; unknown pattern decodes as invalid
        cnt = 0;
        seg = 7'b0011001;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        seg = 7'b0011000;
        tick();
        if (out_valid) cnt++;
        chk("t3_no_early", cnt, 0);
        seg = 7'b0011001;
        wait_valid("t3_valid", 20, n);
        chk("t3_latency", n, S + 1);
        chk("t3_code", out_code, 4);
        seg = 7'b0011000;
        wait_valid("t3_inv_valid", 20, n);
        chk("t3_inv_code", out_code, 0);
        chk("t3_inv_flag", out_inval, 1);
        tick();

        // 4: backpressure loses the second event and sets overrun
        ready = 0;
        sel   = 4'b0010;
        seg   = 7'b0001000;
        wait_valid("t4_valid", 20, n);
        sel = 4'b0100;
        seg = 7'b1000110;
        for (int i = 0; i < S + 3; i++) tick();
        chk("t4_held_valid", out_valid, 1);
        chk("t4_held_code", out_code, 4'hB);
        chk("t4_held_digit", out_digit, 1);
        chk("t4_overrun", overrun, 1);
        ready = 1;
        tick();
        chk("t4_drained", out_valid, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("t4_single_xfer", cnt, 0);

        // 6: reset while holding discards the event and clears the shadow
        ready = 0;
        sel   = 4'b0001;
        seg   = 7'b0100100;
        wait_valid("t6_valid", 20, n);
        tick();
        tick();
        rst = 1;
        tick();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_overrun", overrun, 0);
        rst = 0;
        wait_valid("t6_resend", 20, n);
        chk("t6_latency", n, S + 1);
        chk("t6_code", out_code, 2);
        chk("t6_digit", out_digit, 0);
        ready = 1;
        tick();

        // 5: transfer and new event in the same cycle
        ready = 0;
        sel   = 4'b1000;
        seg   = 7'b1111000;
        wait_valid("t5_first", 20, n);
        sel = 4'b0001;
        seg = 7'b0010000;
        for (int i = 0; i < S; i++) tick();
        chk("t5_first_code", out_code, 7);
        chk("t5_first_digit", out_digit, 3);
        ready = 1;
        tick();
        chk("t5_second_valid", out_valid, 1);
        chk("t5_second_code", out_code, 9);
        chk("t5_second_digit", out_digit, 0);
        chk("t5_overrun", overrun, 0);
        tick();
        chk("t5_done", out_valid, 0);
        chk("t5_overrun_end", overrun, 0);

        // Randomized traffic checked against the model every cycle
        for (int seq = 0; seq < 300; seq++) begin
            int len;
            if ($urandom_range(0, 99) < 80) seg = pat_tab[$urandom_range(0, 15)];
            else seg = 7'($urandom);
            if ($urandom_range(0, 99) < 85) sel = 4'(1 << $urandom_range(0, D - 1));
            else sel = 4'($urandom);
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                ready = ($urandom_range(0, 99) < 60);
                rst   = ($urandom_range(0, 499) == 0);
                tick();
            end
            rst = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
